// File: rtl/control_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// cpu4_pkg
// Shared definitions for the 4-bit CPU control sequencer: FSM state encoding,
// instruction class and control sub-op codes, ControlWord bit positions and
// a helper that packs ControlWord fields.
// No ports (package).
// ----------------------------------------------------------------------------
package cpu4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WAIT_IN,
        ST_HALT
    } state_e;

    // Instruction class, taken from instr[15:14]
    localparam logic [1:0] CLS_ALU_RR = 2'b00;
    localparam logic [1:0] CLS_ALU_RI = 2'b01;
    localparam logic [1:0] CLS_LOAD   = 2'b10;
    localparam logic [1:0] CLS_CTRL   = 2'b11;

    // Control sub-op, taken from instr[13:12] when the class is CLS_CTRL
    localparam logic [1:0] SUB_HALT = 2'b00;
    localparam logic [1:0] SUB_JMP  = 2'b01;
    localparam logic [1:0] SUB_JZ   = 2'b10;
    localparam logic [1:0] SUB_NOP  = 2'b11;

    // ControlWord bit positions
    localparam int CW_DA_LSB = 11;
    localparam int CW_AA_LSB = 9;
    localparam int CW_BA_LSB = 7;
    localparam int CW_MB     = 6;
    localparam int CW_FS_LSB = 2;
    localparam int CW_MD     = 1;
    localparam int CW_NWE    = 0;

    // No write, everything else zero
    localparam logic [12:0] CW_IDLE = 13'h0001;

    function automatic logic [12:0] make_cw(
        input logic [1:0] da,
        input logic [1:0] aa,
        input logic [1:0] ba,
        input logic       mb,
        input logic [3:0] fs,
        input logic       md,
        input logic       nwe
    );
        logic [12:0] cw;
        cw                    = '0;
        cw[CW_DA_LSB +: 2]    = da;
        cw[CW_AA_LSB +: 2]    = aa;
        cw[CW_BA_LSB +: 2]    = ba;
        cw[CW_MB]             = mb;
        cw[CW_FS_LSB +: 4]    = fs;
        cw[CW_MD]             = md;
        cw[CW_NWE]            = nwe;
        return cw;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// ----------------------------------------------------------------------------
// control_sequencer_if
// Groups the program-memory bus and the data_in handshake of the sequencer.
//   imem_addr [PC_W] : program memory address (sequencer -> memory)
//   imem_data [16]   : instruction word, one cycle after imem_addr
//   in_valid         : external data_in is valid
//   in_ready         : sequencer accepts data_in this cycle
// Modports: master = sequencer side, slave = memory / input source side.
// ----------------------------------------------------------------------------
interface control_sequencer_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_data;
    logic            in_valid;
    logic            in_ready;

    modport master (
        output imem_addr,
        input  imem_data,
        input  in_valid,
        output in_ready
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output in_valid,
        input  in_ready
    );
endinterface

// File: rtl/control_sequencer_ctrl_decode.sv
// ----------------------------------------------------------------------------
// ctrl_decode
// Combinational map from FSM state and latched instruction to the datapath
// ControlWord and ConstantIn.
//   state       : current sequencer state
//   ir          : latched instruction register
//   in_valid    : input handshake valid (only used while waiting for a load)
//   control_word: DA,AA,BA,MB,FS,MD,nWE
//   constant_in : immediate operand for register-immediate ALU ops
// ----------------------------------------------------------------------------
module ctrl_decode
    import cpu4_pkg::*;
(
    input  state_e      state,
    input  logic [15:0] ir,
    input  logic        in_valid,
    output logic [12:0] control_word,
    output logic [3:0]  constant_in
);

    always_comb begin
        control_word = CW_IDLE;
        constant_in  = '0;
        case (state)
            ST_EXEC: begin
                case (ir[15:14])
                    CLS_ALU_RR: control_word = make_cw(ir[13:12], ir[11:10], ir[9:8],
                                                       1'b0, ir[7:4], 1'b0, 1'b0);
                    CLS_ALU_RI: begin
                        control_word = make_cw(ir[13:12], ir[11:10], ir[9:8],
                                               1'b1, ir[7:4], 1'b0, 1'b0);
                        constant_in  = ir[3:0];
                    end
                    default: ;
                endcase
            end
            // The load writes on the edge where in_valid is seen, so nWE
            // follows in_valid combinationally here.
            ST_WAIT_IN: control_word = make_cw(ir[13:12], ir[11:10], ir[9:8],
                                               1'b0, ir[7:4], 1'b1, ~in_valid);
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer
// Multicycle control unit for the 4-bit datapath: fetches 16-bit
// instructions, decodes them and sequences one register write each.
//   clk, nRST    : clock, asynchronous active-low reset
//   start        : pulse to begin execution at address 0 from IDLE or HALT
//   bus          : program memory bus and data_in handshake (master side)
//   Reg0..Reg3   : datapath register contents, used by JZ
//   ControlWord  : DA,AA,BA,MB,FS,MD,nWE to the datapath
//   ConstantIn   : immediate operand
//   busy, halted : status
// ----------------------------------------------------------------------------
module control_sequencer
    import cpu4_pkg::*;
#(
    parameter int PC_W = 8
)
(
    input  logic                clk,
    input  logic                nRST,
    input  logic                start,
    control_sequencer_if.master bus,
    input  logic [3:0]          Reg0,
    input  logic [3:0]          Reg1,
    input  logic [3:0]          Reg2,
    input  logic [3:0]          Reg3,
    output logic [12:0]         ControlWord,
    output logic [3:0]          ConstantIn,
    output logic                busy,
    output logic                halted
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic            armed_q;

    logic [3:0]      reg_aa;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] jump_target;

    // Register selected by the AA field, for the JZ zero test
    always_comb begin
        case (ir_q[11:10])
            2'd0:    reg_aa = Reg0;
            2'd1:    reg_aa = Reg1;
            2'd2:    reg_aa = Reg2;
            default: reg_aa = Reg3;
        endcase
    end

    assign pc_inc      = pc_q + PC_W'(1);
    assign jump_target = PC_W'(ir_q[7:0]);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            // armed_q keeps a start pulse that coincides with reset release
            // from launching execution.
            ST_IDLE, ST_HALT: begin
                if (start && armed_q) begin
                    pc_d    = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                ir_d    = bus.imem_data;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (ir_q[15:14])
                    CLS_ALU_RR, CLS_ALU_RI: pc_d = pc_inc;
                    CLS_LOAD:               state_d = ST_WAIT_IN;
                    default: begin
                        case (ir_q[13:12])
                            SUB_HALT: state_d = ST_HALT;
                            SUB_JMP:  pc_d = jump_target;
                            SUB_JZ:   pc_d = (reg_aa == 4'd0) ? jump_target : pc_inc;
                            default:  pc_d = pc_inc;
                        endcase
                    end
                endcase
            end
            ST_WAIT_IN: begin
                if (bus.in_valid) begin
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            armed_q <= 1'b1;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.in_ready  = (state_q == ST_WAIT_IN);
    assign busy          = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted        = (state_q == ST_HALT);

    ctrl_decode u_ctrl_decode (
        .state        (state_q),
        .ir           (ir_q),
        .in_valid     (bus.in_valid),
        .control_word (ControlWord),
        .constant_in  (ConstantIn)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_control_sequencer
// Directed programs plus a randomized run of control_sequencer. An
// instruction-level reference model predicts every output each cycle; a few
// literal expectations pin down the model at known points.
// ----------------------------------------------------------------------------
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        nRST;
    logic        start;
    logic        in_valid;
    logic [3:0]  reg_v [4];
    logic [12:0] ControlWord;
    logic [3:0]  ConstantIn;
    logic        busy;
    logic        halted;
    logic [15:0] mem [256];

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    control_sequencer_if #(.PC_W(8)) bus_if ();

    assign bus_if.in_valid = in_valid;

    // Synchronous program memory, one cycle read latency
    always @(posedge clk) bus_if.imem_data <= mem[bus_if.imem_addr];

    control_sequencer #(.PC_W(8)) dut (
        .clk         (clk),
        .nRST        (nRST),
        .start       (start),
        .bus         (bus_if),
        .Reg0        (reg_v[0]),
        .Reg1        (reg_v[1]),
        .Reg2        (reg_v[2]),
        .Reg3        (reg_v[3]),
        .ControlWord (ControlWord),
        .ConstantIn  (ConstantIn),
        .busy        (busy),
        .halted      (halted)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive inputs for the current cycle, then advance to the next one
    task automatic applyStimulus(input logic s, input logic v);
        start    = s;
        in_valid = v;
        nextCycle();
    endtask

    task automatic fillMem(input logic [15:0] word);
        for (int i = 0; i < 256; i++) mem[i] = word;
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks the running program one instruction at a
    // time (pc plus the cycle offset inside the current instruction) and
    // predicts the outputs of the present cycle from the instruction rules.
    // ------------------------------------------------------------------
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    int         m_mode = M_IDLE;
    logic [7:0] m_pc   = 8'd0;
    int         m_k    = 0;

    always @(negedge clk) begin : model
        logic [15:0] ins;
        logic [12:0] e_cw;
        logic [3:0]  e_ci;
        logic        e_rdy;
        if (!nRST) begin
            m_mode = M_IDLE;
            m_pc   = 8'd0;
            m_k    = 0;
            checkOutput("rst_cw",     ControlWord, 13'h0001);
            checkOutput("rst_ci",     ConstantIn, 4'd0);
            checkOutput("rst_addr",   bus_if.imem_addr, 8'd0);
            checkOutput("rst_busy",   busy, 1'b0);
            checkOutput("rst_halted", halted, 1'b0);
            checkOutput("rst_ready",  bus_if.in_ready, 1'b0);
        end else begin
            ins   = mem[m_pc];
            e_cw  = 13'h0001;
            e_ci  = 4'd0;
            e_rdy = 1'b0;
            if (m_mode == M_RUN && m_k == 2 && ins[15] == 1'b0) begin
                e_cw = {ins[13:8], ins[14], ins[7:4], 2'b00};
                if (ins[14]) e_ci = ins[3:0];
            end
            if (m_mode == M_RUN && m_k >= 3) begin
                e_cw  = {ins[13:8], 1'b0, ins[7:4], 1'b1, ~in_valid};
                e_rdy = 1'b1;
            end
            checkOutput("cw",     ControlWord, e_cw);
            checkOutput("ci",     ConstantIn, e_ci);
            checkOutput("ready",  bus_if.in_ready, e_rdy);
            checkOutput("busy",   busy, m_mode == M_RUN);
            checkOutput("halted", halted, m_mode == M_HALT);
            if (m_mode == M_RUN && m_k == 0)
                checkOutput("fetch_addr", bus_if.imem_addr, m_pc);

            // Advance to what the next cycle should look like
            if (m_mode == M_RUN) begin
                if (m_k < 2) begin
                    m_k++;
                end else if (m_k == 2) begin
                    m_k = 0;
                    case (ins[15:14])
                        2'b00, 2'b01: m_pc = m_pc + 8'd1;
                        2'b10:        m_k = 3;
                        default: begin
                            case (ins[13:12])
                                2'b00: m_mode = M_HALT;
                                2'b01: m_pc = ins[7:0];
                                2'b10: m_pc = (reg_v[ins[11:10]] == 4'd0) ? ins[7:0] : m_pc + 8'd1;
                                default: m_pc = m_pc + 8'd1;
                            endcase
                        end
                    endcase
                end else if (in_valid) begin
                    m_pc = m_pc + 8'd1;
                    m_k  = 0;
                end
            end else if (start) begin
                m_mode = M_RUN;
                m_pc   = 8'd0;
                m_k    = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int cool;
        start    = 1'b0;
        in_valid = 1'b0;
        for (int r = 0; r < 4; r++) reg_v[r] = 4'd0;
        fillMem(16'hC000);
        nRST = 1'b1;
        #1 nRST = 1'b0;
        #1;
        checkOutput("por_cw",   ControlWord, 13'h0001);
        checkOutput("por_addr", bus_if.imem_addr, 8'd0);
        checkOutput("por_busy", busy, 1'b0);
        nextCycle();
        nRST = 1'b1;

        // Stays idle without start
        repeat (10) applyStimulus(1'b0, 1'b0);
        checkOutput("idle_busy", busy, 1'b0);
        checkOutput("idle_halted", halted, 1'b0);

        // Program A: R1 <- imm 5, then R2 <- R1 op R1, then HALT
        $display("[TB] program A: ALU immediate and register-register");
        mem[0] = 16'h5035;
        mem[1] = 16'h2520;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        #2;
        checkOutput("a_exec0_cw", ControlWord, {2'd1, 2'd0, 2'd0, 1'b1, 4'd3, 1'b0, 1'b0});
        checkOutput("a_exec0_ci", ConstantIn, 4'd5);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        #2;
        checkOutput("a_exec1_cw", ControlWord, {2'd2, 2'd1, 2'd1, 1'b0, 4'd2, 1'b0, 1'b0});
        checkOutput("a_exec1_ci", ConstantIn, 4'd0);
        applyStimulus(1'b0, 1'b0);
        #2;
        checkOutput("a_pc2", bus_if.imem_addr, 8'd2);
        repeat (3) applyStimulus(1'b0, 1'b0);
        #2;
        checkOutput("a_halted", halted, 1'b1);
        checkOutput("a_busy", busy, 1'b0);
        checkOutput("a_halt_cw", ControlWord, 13'h0001);

        // Restart from HALT fetches address 0 again
        applyStimulus(1'b1, 1'b0);
        #2;
        checkOutput("restart_addr", bus_if.imem_addr, 8'd0);
        checkOutput("restart_busy", busy, 1'b1);
        repeat (9) applyStimulus(1'b0, 1'b0);
        #2;
        checkOutput("restart_halted", halted, 1'b1);

        // Program B: LOAD with three idle WAIT_IN cycles
        $display("[TB] program B: load handshake");
        fillMem(16'hC000);
        mem[0] = 16'hB900;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        #2;
        checkOutput("b_exec_cw", ControlWord, 13'h0001);
        checkOutput("b_exec_ready", bus_if.in_ready, 1'b0);
        applyStimulus(1'b0, 1'b0);
        for (int w = 0; w < 4; w++) begin
            in_valid = (w == 3);
            #2;
            checkOutput("b_wait_ready", bus_if.in_ready, 1'b1);
            checkOutput("b_wait_cw", ControlWord,
                        {2'd3, 2'd2, 2'd1, 1'b0, 4'd0, 1'b1, (w != 3)});
            nextCycle();
        end
        in_valid = 1'b0;
        #2;
        checkOutput("b_next_addr", bus_if.imem_addr, 8'd1);
        checkOutput("b_next_ready", bus_if.in_ready, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0);
        #2;
        checkOutput("b_halted", halted, 1'b1);

        // Reset while waiting for input aborts without a write
        applyStimulus(1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0);
        #2;
        checkOutput("b2_waiting", bus_if.in_ready, 1'b1);
        nRST = 1'b0;
        #1;
        checkOutput("b2_rst_cw", ControlWord, 13'h0001);
        checkOutput("b2_rst_ready", bus_if.in_ready, 1'b0);
        checkOutput("b2_rst_busy", busy, 1'b0);
        nextCycle();
        nRST = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b0);

        // Program C: JMP, JZ taken, JZ not taken, JMP to FF, NOP wraps
        $display("[TB] program C: jumps and pc wrap");
        fillMem(16'hC000);
        mem[8'h00] = 16'hD010;
        mem[8'h10] = 16'hE820;
        mem[8'h20] = 16'hE840;
        mem[8'h21] = 16'hD0FF;
        mem[8'hFF] = 16'hF000;
        applyStimulus(1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0);
        #2;
        checkOutput("c_jmp", bus_if.imem_addr, 8'h10);
        repeat (3) applyStimulus(1'b0, 1'b0);
        #2;
        checkOutput("c_jz_taken", bus_if.imem_addr, 8'h20);
        reg_v[2] = 4'h3;
        repeat (3) applyStimulus(1'b0, 1'b0);
        #2;
        checkOutput("c_jz_not_taken", bus_if.imem_addr, 8'h21);
        repeat (3) applyStimulus(1'b0, 1'b0);
        #2;
        checkOutput("c_jmp_ff", bus_if.imem_addr, 8'hFF);
        repeat (3) applyStimulus(1'b0, 1'b0);
        #2;
        checkOutput("c_wrap", bus_if.imem_addr, 8'h00);
        repeat (5) applyStimulus(1'b0, 1'b0);
        #2;
        checkOutput("c_before_rst", bus_if.imem_addr, 8'h10);
        nRST = 1'b0;
        #1;
        checkOutput("c_rst_addr", bus_if.imem_addr, 8'h00);
        checkOutput("c_rst_busy", busy, 1'b0);
        nextCycle();
        nRST = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b0);

        // Randomized run against the model
        $display("[TB] randomized run");
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        cool = 3;
        for (int c = 0; c < 4000; c++) begin
            if (!nRST) begin
                nRST = 1'b1;
                cool = 3;
            end else if ($urandom_range(0, 299) == 0) begin
                nRST = 1'b0;
            end
            start    = nRST && (cool == 0) && ($urandom_range(0, 7) == 0);
            if (cool > 0) cool--;
            in_valid = ($urandom_range(0, 9) < 4);
            for (int r = 0; r < 4; r++)
                reg_v[r] = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 15));
            nextCycle();
        end
        nRST = 1'b1;
        start = 1'b0;
        nextCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multicycle control unit that sits directly upstream of the 4-bit datapath and generates its 13-bit `ControlWord` and `ConstantIn` every cycle. It fetches 16-bit instructions from a synchronous program memory, decodes them, and sequences one register-file write per instruction. It also handles an input handshake for loads and a zero-test branch that reads the datapath's register outputs.

## Interface
- `PC_W`, default 8: program counter and `imem_addr` width.
- `clk` in 1: single clock; every state change happens on the rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins execution from address 0 when in IDLE or HALT.
- `imem_addr` out PC_W: program memory address; read latency is 1 cycle.
- `imem_data` in 16: instruction word returned for `imem_addr`.
- `in_valid` in 1: external `data_in` value is valid.
- `in_ready` out 1: sequencer accepts `data_in` this cycle.
- `Reg0`..`Reg3` in 4 each: datapath register contents, used for JZ.
- `ControlWord` out 13: DA[12:11], AA[10:9], BA[8:7], MB[6], FS[5:2], MD[1], nWE[0].
- `ConstantIn` out 4: immediate value for the datapath.
- `busy` out 1: high in every state except IDLE and HALT.
- `halted` out 1: high in HALT.

## Operation
- Instruction fields: class[15:14], DA[13:12], AA[11:10], BA[9:8], FS[7:4], imm[3:0].
- Class 00 ALU register-register: MB=0, MD=0, nWE=0.
- Class 01 ALU register-immediate: MB=1, ConstantIn=imm, MD=0, nWE=0.
- Class 10 LOAD: MD=1, write to DA via handshake.
- Class 11 control; sub-op in [13:12]:
  - 00 HALT.
  - 01 JMP: pc←instr[7:0].
  - 10 JZ: if Reg[AA]==0 then pc←instr[7:0], else pc+1.
  - 11 NOP.
- Jump target is truncated or zero-extended to PC_W.
- Idle ControlWord is 13'h0001: nWE=1, all other bits 0. It is driven in every state and cycle that does not perform a write.
- ConstantIn is 0 unless the EXEC instruction is class 01.
- States:
  - IDLE: on `start`, go to FETCH.
  - FETCH: drive imem_addr=pc, then go to DECODE.
  - DECODE: latch imem_data into IR, then go to EXEC.
  - EXEC:
    - Class 00/01: drive the write word; pc+1; go to FETCH.
    - Class 10: go to WAIT_IN; pc is unchanged.
    - JMP/JZ/NOP: update pc; go to FETCH.
    - HALT: go to HALT; pc is unchanged.
  - WAIT_IN: in_ready=1; ControlWord = {DA,AA,BA,0,FS,1,~in_valid}. On in_valid: the write happens on this edge, then pc+1 and go to FETCH.
  - HALT: on `start`, pc←0 and go to FETCH.
- `start` is ignored while busy.
- `in_valid` is ignored outside WAIT_IN.
- pc increments modulo 2^PC_W: all-ones wraps to 0.
- JZ samples Reg[AA] in the EXEC cycle. Because the previous write committed at the preceding EXEC/WAIT_IN edge, no forwarding is required.

## Timing
- Reset (asynchronous, immediate) sets:
  - State: IDLE.
  - pc, IR, imem_addr: 0.
  - ControlWord: 13'h0001.
  - ConstantIn, in_ready, busy, halted: 0.
- Reset mid-instruction, including WAIT_IN, aborts with no write. No write may occur on the edge on which nRST deasserts.
- Cycle counts:
  - ALU, jump, NOP: 3 cycles (FETCH, DECODE, EXEC).
  - LOAD: 3 + N cycles, where N ≥ 1 is the number of WAIT_IN cycles up to and including the in_valid cycle.
- nWE=0 for exactly one cycle per ALU or LOAD instruction, never otherwise.
- In WAIT_IN, nWE depends combinationally on in_valid. All other outputs are decoded from registered state and IR only.
- `start` coincident with reset deassertion is ignored.

## Structure
- Package `cpu4_pkg` holds:
  - The state enum.
  - Class and sub-op codes.
  - ControlWord bit-position constants.
  - `CW_IDLE` = 13'h0001.
- One combinational sub-module, `ctrl_decode`: maps IR plus state to ControlWord and ConstantIn.
- The FSM, pc, and IR live in `control_sequencer`.

## Test plan
- Reset state: assert nRST=0 mid-run → ControlWord=13'h0001, imem_addr=0, busy=0 immediately. With no `start`, the block stays IDLE for 10 cycles.
- ALU immediate then register-register:
  - Program [0]=01_01_00_00_FS_0101 (R1←imm 5), then [1]=class 00 with DA=2, AA=1, BA=1.
  - Expect nWE low at cycles 3 and 6 after start, DA=1 then DA=2, ConstantIn=5 only in the first EXEC, and pc=2.
- LOAD handshake:
  - Hold in_valid=0 for 3 cycles of WAIT_IN, then raise it.
  - Expect in_ready=1 for 4 cycles, a single nWE=0 cycle coincident with in_valid, MD=1, then FETCH with pc+1.
- JZ:
  - With Reg2=0 and target 8'h20 → pc=8'h20.
  - With Reg2=4'h3 → pc=old pc+1.
  - JMP to 8'hFF followed by NOP → pc wraps to 0.
- Halt and restart:
  - A HALT instruction → halted=1, busy=0, nWE stays 1, and `start` pulses issued during execution are ignored.
  - A `start` pulse in HALT → fetch from address 0.
